// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB completer memory.
package apb_slv_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    ACCESS
  } apb_slv_state_e;

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x DATA_W storage: async reset, one write port, one combinational read port.
module apb_slv_regfile #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Callers only write in-range addresses; out-of-range reads are masked upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr[IdxW-1:0]] <= wdata;
    end
  end

  assign rdata = mem[raddr[IdxW-1:0]];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a byte-wide register file, with programmable wait states.
// Define APB_SLV_RO_EN to make addresses >= RO_BASE read-only (writes there error out).
module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int unsigned       ADDR_W      = APB_ADDR_W,
  parameter int unsigned       DATA_W      = APB_DATA_W,
  parameter int unsigned       DEPTH       = 256,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RO_BASE     = 8'hF0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

`ifdef APB_SLV_RO_EN
  localparam bit RoEn = 1'b1;
`else
  localparam bit RoEn = 1'b0;
`endif

  localparam logic [ADDR_W:0]       DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WaitLoad =
      (WAIT_CYCLES >= 2) ? WAIT_CNT_W'(WAIT_CYCLES - 2) : '0;

  apb_slv_state_e        state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  write_q;
  logic                  err_q;

  logic                  take_setup;
  logic                  setup_err;
  logic                  complete;
  logic                  we;
  logic [ADDR_W-1:0]     cur_addr;
  logic [DATA_W-1:0]     cur_wdata;
  logic                  cur_write;
  logic                  cur_err;
  logic [DATA_W-1:0]     rdata;

  assign take_setup = PSEL && !PENABLE && (state_q == IDLE || state_q == ACCESS);
  assign setup_err  = ({1'b0, PADDR} >= DepthW) || (RoEn && PWRITE && (PADDR >= RO_BASE));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The registered PREADY is decided one edge ahead: SETUP is the first access-phase
  // cycle and WAIT covers the remaining PREADY-low cycles, so completion takes
  // WAIT_CYCLES+1 access cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, ACCESS: begin
        if (take_setup) begin
          state_d = (WAIT_CYCLES == 0) ? ACCESS : SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (WAIT_CYCLES <= 1) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = WaitLoad;
          end
        end
      end
      WAIT: begin
        if (!PSEL || !PENABLE) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-wait transfers complete on the setup edge, so the live bus feeds the access.
  always_comb begin
    cur_addr  = take_setup ? PADDR : addr_q;
    cur_wdata = take_setup ? PWDATA : wdata_q;
    cur_write = take_setup ? PWRITE : write_q;
    cur_err   = take_setup ? setup_err : err_q;
    complete  = (state_d == ACCESS);
    we        = complete && cur_write && !cur_err;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      if (take_setup) begin
        addr_q  <= PADDR;
        wdata_q <= PWDATA;
        write_q <= PWRITE;
        err_q   <= setup_err;
      end
      PREADY  <= complete;
      PSLVERR <= complete && cur_err;
      if (complete && !cur_write) begin
        PRDATA <= cur_err ? '0 : rdata;
      end
    end
  end

  apb_slv_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk  (PCLK),
    .rst_n(PRESETn),
    .we   (we),
    .waddr(cur_addr),
    .wdata(cur_wdata),
    .raddr(cur_addr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: four instances share one APB bus, one PSEL each.
module tb_apb_slave_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] psel = '0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = '0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata [4];
  logic       pready [4];
  logic       pslverr [4];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // 0: defaults (WAIT_CYCLES=1), 1: zero-wait, 2: DEPTH=128, 3: WAIT_CYCLES=3
  apb_slave_mem #(.WAIT_CYCLES(1)) u_dut_w1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );
  apb_slave_mem #(.WAIT_CYCLES(0)) u_dut_w0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );
  apb_slave_mem #(.DEPTH(128), .WAIT_CYCLES(1)) u_dut_d128 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
  );
  apb_slave_mem #(.WAIT_CYCLES(3)) u_dut_w3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[3]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[3]), .PREADY(pready[3]), .PSLVERR(pslverr[3])
  );

  // One APB transfer on instance d; cycles = access cycles until PREADY, -1 on timeout.
  task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                      input logic [7:0] data, input bit scramble,
                      output logic [7:0] rdata, output logic err, output int cycles);
    @(negedge clk);
    psel = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = addr;
    pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    cycles = 1;
    while (pready[d] !== 1'b1 && cycles < 20) begin
      if (scramble) begin
        paddr = addr + 8'h01;
        pwdata = ~data;
        pwrite = ~wr;
      end
      @(negedge clk);
      cycles++;
    end
    rdata = prdata[d];
    err = pslverr[d];
    if (pready[d] !== 1'b1) cycles = -1;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel = '0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic       er;
    int         cyc;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if ({prdata[d], pready[d], pslverr[d]} !== 10'h000) begin
        $display("FAIL reset_outputs[%0d]: got prdata=%h pready=%b pslverr=%b, want 00/0/0",
                 d, prdata[d], pready[d], pslverr[d]);
        n_fail++;
      end
    end
    rst_n = 1'b1;
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, rd, er, cyc);
    bus_idle();
    n_checks++;
    if (rd !== 8'h00 || cyc !== 2) begin
      $display("FAIL reset_read_10: got data=%h cycles=%0d, want 00 cycles=2", rd, cyc);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    logic       er;
    int         cyc;
    @(negedge clk);
    psel = 4'b1000;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h30;
    pwdata = 8'h99;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pready[3] !== 1'b0) begin
      $display("FAIL reset_mid_pready: got %b, want 0", pready[3]);
      n_fail++;
    end
    rst_n = 1'b1;
    psel = '0;
    penable = 1'b0;
    xfer(3, 1'b0, 8'h30, 8'h00, 1'b0, rd, er, cyc);
    bus_idle();
    n_checks++;
    if (rd !== 8'h00) begin
      $display("FAIL reset_mid_no_write: got %h, want 00", rd);
      n_fail++;
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd;
    logic       er;
    int         cyc;
    xfer(0, 1'b1, 8'h10, 8'h5A, 1'b0, rd, er, cyc);
    n_checks++;
    if (cyc !== 2 || er !== 1'b0) begin
      $display("FAIL w1_write: got cycles=%0d err=%b, want cycles=2 err=0", cyc, er);
      n_fail++;
    end
    bus_idle();
    xfer(0, 1'b0, 8'h10, 8'h00, 1'b0, rd, er, cyc);
    bus_idle();
    n_checks++;
    if (cyc !== 2) begin
      $display("FAIL w1_read_latency: got %0d access cycles, want 2", cyc);
      n_fail++;
    end
    n_checks++;
    if (rd !== 8'h5A || er !== 1'b0) begin
      $display("FAIL w1_read_data: got %h err=%b, want 5a err=0", rd, er);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic       er;
    int         cyc_w, cyc_r;
    bit         saw_ready;
    xfer(1, 1'b1, 8'h01, 8'hA5, 1'b0, rd, er, cyc_w);
    xfer(1, 1'b0, 8'h01, 8'h00, 1'b0, rd, er, cyc_r);
    bus_idle();
    n_checks++;
    if (cyc_w !== 1 || cyc_r !== 1) begin
      $display("FAIL b2b_latency: got write=%0d read=%0d access cycles, want 1 and 1", cyc_w, cyc_r);
      n_fail++;
    end
    n_checks++;
    if (rd !== 8'hA5 || er !== 1'b0) begin
      $display("FAIL b2b_read_data: got %h err=%b, want a5 err=0", rd, er);
      n_fail++;
    end
    // Access phase without a setup phase must be ignored.
    @(negedge clk);
    psel = 4'b0010;
    penable = 1'b1;
    pwrite = 1'b1;
    paddr = 8'h01;
    pwdata = 8'hEE;
    saw_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready[1] === 1'b1) saw_ready = 1'b1;
    end
    psel = '0;
    penable = 1'b0;
    n_checks++;
    if (saw_ready !== 1'b0) begin
      $display("FAIL no_setup_pready: got PREADY=1, want never");
      n_fail++;
    end
    xfer(1, 1'b0, 8'h01, 8'h00, 1'b0, rd, er, cyc_r);
    bus_idle();
    n_checks++;
    if (rd !== 8'hA5) begin
      $display("FAIL no_setup_data: got %h, want a5", rd);
      n_fail++;
    end
  endtask

  task automatic test_range();
    logic [7:0] rd;
    logic       er;
    int         cyc;
    xfer(2, 1'b1, 8'h80, 8'hFF, 1'b0, rd, er, cyc);
    n_checks++;
    if (er !== 1'b1 || cyc !== 2) begin
      $display("FAIL oor_write: got err=%b cycles=%0d, want err=1 cycles=2", er, cyc);
      n_fail++;
    end
    xfer(2, 1'b1, 8'h7F, 8'hAB, 1'b0, rd, er, cyc);
    n_checks++;
    if (er !== 1'b0) begin
      $display("FAIL last_word_write: got err=%b, want 0", er);
      n_fail++;
    end
    xfer(2, 1'b0, 8'h80, 8'h00, 1'b0, rd, er, cyc);
    n_checks++;
    if (rd !== 8'h00 || er !== 1'b1) begin
      $display("FAIL oor_read: got %h err=%b, want 00 err=1", rd, er);
      n_fail++;
    end
    xfer(2, 1'b0, 8'h7F, 8'h00, 1'b0, rd, er, cyc);
    bus_idle();
    n_checks++;
    if (rd !== 8'hAB || er !== 1'b0) begin
      $display("FAIL last_word_read: got %h err=%b, want ab err=0", rd, er);
      n_fail++;
    end
    // Errored write to 0x80 must not alias onto word 0.
    xfer(2, 1'b0, 8'h00, 8'h00, 1'b0, rd, er, cyc);
    bus_idle();
    n_checks++;
    if (rd !== 8'h00) begin
      $display("FAIL oor_alias: got %h at 00, want 00", rd);
      n_fail++;
    end
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    logic       er;
    int         cyc;
    bit         saw_ready;
    xfer(3, 1'b1, 8'h20, 8'h11, 1'b0, rd, er, cyc);
    n_checks++;
    if (cyc !== 4 || er !== 1'b0) begin
      $display("FAIL w3_latency: got cycles=%0d err=%b, want 4 err=0", cyc, er);
      n_fail++;
    end
    xfer(3, 1'b0, 8'h20, 8'h00, 1'b0, rd, er, cyc);
    bus_idle();
    @(negedge clk);
    psel = 4'b1000;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 8'h20;
    pwdata = 8'h33;
    @(negedge clk);
    penable = 1'b1;
    saw_ready = (pready[3] === 1'b1);
    @(negedge clk);
    if (pready[3] === 1'b1) saw_ready = 1'b1;
    psel = '0;
    penable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (pready[3] === 1'b1 || pslverr[3] === 1'b1) saw_ready = 1'b1;
    end
    n_checks++;
    if (saw_ready !== 1'b0) begin
      $display("FAIL abort_pready: got PREADY/PSLVERR=1, want never");
      n_fail++;
    end
    n_checks++;
    if (prdata[3] !== 8'h11) begin
      $display("FAIL abort_prdata_hold: got %h, want 11", prdata[3]);
      n_fail++;
    end
    xfer(3, 1'b0, 8'h20, 8'h00, 1'b0, rd, er, cyc);
    bus_idle();
    n_checks++;
    if (rd !== 8'h11) begin
      $display("FAIL abort_no_write: got %h, want 11", rd);
      n_fail++;
    end
  endtask

  task automatic test_ro();
    logic [7:0] rd;
    logic       er;
    int         cyc;
    logic       exp_err;
    logic [7:0] exp_rd;
`ifdef APB_SLV_RO_EN
    exp_err = 1'b1;
    exp_rd = 8'h00;
`else
    exp_err = 1'b0;
    exp_rd = 8'h77;
`endif
    xfer(0, 1'b1, 8'hF4, 8'h77, 1'b0, rd, er, cyc);
    n_checks++;
    if (er !== exp_err) begin
      $display("FAIL ro_write_err: got %b, want %b", er, exp_err);
      n_fail++;
    end
    xfer(0, 1'b0, 8'hF4, 8'h00, 1'b0, rd, er, cyc);
    bus_idle();
    n_checks++;
    if (rd !== exp_rd || er !== 1'b0) begin
      $display("FAIL ro_read: got %h err=%b, want %h err=0", rd, er, exp_rd);
      n_fail++;
    end
  endtask

  task automatic test_latch();
    logic [7:0] rd;
    logic       er;
    int         cyc;
    xfer(3, 1'b1, 8'h05, 8'hC3, 1'b1, rd, er, cyc);
    xfer(3, 1'b0, 8'h05, 8'h00, 1'b0, rd, er, cyc);
    n_checks++;
    if (rd !== 8'hC3) begin
      $display("FAIL latch_addr05: got %h, want c3", rd);
      n_fail++;
    end
    xfer(3, 1'b0, 8'h06, 8'h00, 1'b0, rd, er, cyc);
    bus_idle();
    n_checks++;
    if (rd !== 8'h00) begin
      $display("FAIL latch_addr06: got %h, want 00", rd);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_write_read();
    test_back_to_back();
    test_range();
    test_abort();
    test_ro();
    test_latch();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
